// File: rtl/ps2_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ps2_pkg: PS/2 code constants and receive-state type.
// Rev 1.0
// ------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_BAT = 8'hAA;

    localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;
    localparam logic [7:0] PS2_KEY_UP    = 8'h75;
    localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;
    localparam logic [7:0] PS2_KEY_START = 8'h5A;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ------------------------------------------------------------------
// ps2_rx_frame: PS/2 line synchroniser, clock filter, frame FSM, watchdog.
// Rev 1.0
// ------------------------------------------------------------------
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       rx_err_o,
    output logic       rx_flush_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic            filt_q, filt_last_q;
    logic [3:0]      fcnt_q;
    logic            fall;

    rx_state_e       state_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            par_ok_q;
    logic [WD_W-1:0] wd_q;
    logic            valid_q, err_q, flush_q;

    // Filtered clock only flips after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_last_q <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            clk_s1_q    <= ps2_clk_i;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data_i;
            dat_s2_q    <= dat_s1_q;
            filt_last_q <= filt_q;
            if (clk_s2_q == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == 4'(FILTER_LEN - 1)) begin
                filt_q <= ~filt_q;
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + 4'd1;
            end
        end
    end

    assign fall = filt_last_q & ~filt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RX_IDLE;
            bit_q    <= '0;
            shift_q  <= '0;
            par_ok_q <= 1'b0;
            wd_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
            if (fall) begin
                wd_q <= '0;
                case (state_q)
                    RX_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q <= RX_DATA;
                            bit_q   <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        shift_q <= {dat_s2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_ok_q <= odd_parity_ok(shift_q, dat_s2_q);
                        state_q  <= RX_STOP;
                    end
                    RX_STOP: begin
                        state_q <= RX_IDLE;
                        if (dat_s2_q && par_ok_q) begin
                            valid_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b1;
                            flush_q <= 1'b1;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end else if (state_q != RX_IDLE) begin
                if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_q <= RX_IDLE;
                    err_q   <= 1'b1;
                    wd_q    <= '0;
                end else begin
                    wd_q <= wd_q + 1'b1;
                end
            end else begin
                wd_q <= '0;
            end
        end
    end

    assign rx_byte_o  = shift_q;
    assign rx_valid_o = valid_q;
    assign rx_err_o   = err_q;
    assign rx_flush_o = flush_q;

endmodule
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ------------------------------------------------------------------
// ps2_key_tracker: PS/2 prefix decoder and held-key levels for game controls.
// Rev 1.0
// ------------------------------------------------------------------
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_left,
    output logic       key_right,
    output logic       key_up,
    output logic       key_down,
    output logic       key_start,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       scan_break,
    output logic       scan_ext,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err, rx_flush;
    logic [4:0] key_hit;

    logic [4:0] keys_q;
    logic       ext_pend_q, brk_pend_q;
    logic [7:0] scan_code_q;
    logic       scan_valid_q, scan_break_q, scan_ext_q, frame_err_q;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .rx_err_o   (rx_err),
        .rx_flush_o (rx_flush)
    );

    // Bit order of key_hit/keys_q: {start, down, up, right, left}.
    always_comb begin
        key_hit = '0;
        case (rx_byte)
            PS2_KEY_LEFT:  key_hit = 5'b00001;
            PS2_KEY_RIGHT: key_hit = 5'b00010;
            PS2_KEY_UP:    key_hit = 5'b00100;
            PS2_KEY_DOWN:  key_hit = 5'b01000;
            PS2_KEY_START: key_hit = 5'b10000;
            default:       key_hit = 5'b00000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_q       <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            scan_code_q  <= '0;
            scan_valid_q <= 1'b0;
            scan_break_q <= 1'b0;
            scan_ext_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            scan_valid_q <= 1'b0;
            frame_err_q  <= rx_err;
            if (rx_flush) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == PS2_EXT) begin
                    ext_pend_q <= 1'b1;
                end else if (rx_byte == PS2_BRK) begin
                    brk_pend_q <= 1'b1;
                end else begin
                    scan_valid_q <= 1'b1;
                    scan_code_q  <= rx_byte;
                    scan_break_q <= brk_pend_q;
                    scan_ext_q   <= ext_pend_q;
                    ext_pend_q   <= 1'b0;
                    brk_pend_q   <= 1'b0;
                    if (rx_byte == PS2_BAT)
                        keys_q <= '0;
                    else if (brk_pend_q)
                        keys_q <= keys_q & ~key_hit;
                    else
                        keys_q <= keys_q | key_hit;
                end
            end
        end
    end

    assign key_left   = keys_q[0];
    assign key_right  = keys_q[1];
    assign key_up     = keys_q[2];
    assign key_down   = keys_q[3];
    assign key_start  = keys_q[4];
    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign scan_break = scan_break_q;
    assign scan_ext   = scan_ext_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ps2_key_tracker: self-checking bench for ps2_key_tracker.
// Rev 1.0
// ------------------------------------------------------------------
module tb_ps2_key_tracker;

    localparam int FL = 8;
    localparam int TO = 1000;
    localparam int HF = 40;   // fast PS/2 half-period in clk cycles
    localparam int HS = 250;  // 20 us period at 25 MHz

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_left, key_right, key_up, key_down, key_start;
    logic [7:0] scan_code;
    logic       scan_valid, scan_break, scan_ext, frame_err;

    ps2_key_tracker #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_start  (key_start),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .scan_break (scan_break),
        .scan_ext   (scan_ext),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } exp_t;

    typedef struct packed {
        logic [7:0] data;
        logic       badpar;
        logic       scan;
        logic       brk;
        logic       ext;
        logic [4:0] keys;
        logic       err;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] keys_now();
        return {key_start, key_down, key_up, key_right, key_left};
    endfunction

    function automatic logic [10:0] mkframe(input logic [7:0] d, input logic bad);
        return {1'b1, (~^d) ^ bad, d, 1'b0};
    endfunction

    function automatic vec_t mk(input logic [7:0] d, input logic bp, input logic sc,
                                input logic b, input logic e, input logic [4:0] k,
                                input logic er);
        vec_t v;
        v.data = d; v.badpar = bp; v.scan = sc; v.brk = b; v.ext = e; v.keys = k; v.err = er;
        return v;
    endfunction

    // Scoreboard: every strobe is matched against the oldest expected code.
    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (scan_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_scan: got code %0h with nothing expected", scan_code);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("scan_code", 32'(scan_code), 32'(e.code));
                check("scan_break", 32'(scan_break), 32'(e.brk));
                check("scan_ext", 32'(scan_ext), 32'(e.ext));
                check("no_err_with_scan", 32'(frame_err), 32'd0);
            end
        end
    end

    task automatic send_bits(input logic [10:0] fr, input int nbits, input int h);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (h / 2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (h) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (h / 2) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int e0;
        logic [10:0] fr;

        repeat (4) @(negedge clk);
        check("rst_keys", 32'(keys_now()), 32'd0);
        check("rst_scan_code", 32'(scan_code), 32'd0);
        check("rst_scan_valid", 32'(scan_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // First frame at 20 us period with an exact latency check on the stop edge.
        exp_q.push_back('{8'h6B, 1'b0, 1'b0});
        fr = mkframe(8'h6B, 1'b0);
        send_bits(fr, 10, HS);
        ps2_data = 1'b1;
        repeat (HS / 2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL + 3) @(negedge clk);
        check("lat_early", 32'(scan_valid), 32'd0);
        check("lat_key_left_early", 32'(key_left), 32'd0);
        @(negedge clk);
        check("lat_exact", 32'(scan_valid), 32'd1);
        check("lat_key_left", 32'(key_left), 32'd1);
        repeat (HS - FL - 4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HS / 2) @(negedge clk);

        vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 5'b00001, 0));
        vecs.push_back(mk(8'h74, 0, 1, 0, 1, 5'b00011, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 5'b00011, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 5'b00011, 0));
        vecs.push_back(mk(8'h74, 0, 1, 1, 1, 5'b00001, 0));
        vecs.push_back(mk(8'h5A, 1, 0, 0, 0, 5'b00001, 1));
        vecs.push_back(mk(8'h5A, 0, 1, 0, 0, 5'b10001, 0));
        vecs.push_back(mk(8'h5A, 0, 1, 0, 0, 5'b10001, 0));
        vecs.push_back(mk(8'h1C, 0, 1, 0, 0, 5'b10001, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 5'b10001, 0));
        vecs.push_back(mk(8'h5A, 0, 1, 1, 0, 5'b00001, 0));
        vecs.push_back(mk(8'hFA, 0, 1, 0, 0, 5'b00001, 0));
        vecs.push_back(mk(8'h74, 0, 1, 0, 0, 5'b00011, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 5'b00011, 0));
        vecs.push_back(mk(8'h33, 1, 0, 0, 0, 5'b00011, 1));
        vecs.push_back(mk(8'h6B, 0, 1, 0, 0, 5'b00011, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 5'b00011, 0));
        vecs.push_back(mk(8'h75, 0, 1, 0, 1, 5'b00111, 0));
        vecs.push_back(mk(8'hAA, 0, 1, 0, 0, 5'b00000, 0));

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            e0 = err_cnt;
            if (v.scan) exp_q.push_back('{v.data, v.brk, v.ext});
            send_bits(mkframe(v.data, v.badpar), 11, HF);
            repeat (FL + 10) @(negedge clk);
            check($sformatf("v%0d_keys", i), 32'(keys_now()), 32'(v.keys));
            check($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(v.err));
            if (v.scan) begin
                check($sformatf("v%0d_hold_code", i), 32'(scan_code), 32'(v.data));
                check($sformatf("v%0d_hold_brk", i), 32'(scan_break), 32'(v.brk));
            end
        end

        // Partial frame abandoned by the watchdog.
        e0 = err_cnt;
        send_bits(mkframe(8'h75, 1'b0), 4, HF);
        repeat (TO + 50) @(negedge clk);
        check("timeout_err_once", 32'(err_cnt - e0), 32'd1);
        exp_q.push_back('{8'h75, 1'b0, 1'b0});
        send_bits(mkframe(8'h75, 1'b0), 11, HF);
        repeat (FL + 10) @(negedge clk);
        check("after_timeout_keys", 32'(keys_now()), 32'b00100);
        check("after_timeout_err", 32'(err_cnt - e0), 32'd1);

        // Short clock glitch must be filtered out.
        e0 = err_cnt;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HF) @(negedge clk);
        check("glitch_err", 32'(err_cnt - e0), 32'd0);
        check("glitch_keys", 32'(keys_now()), 32'b00100);

        // Reset mid-frame clears outputs asynchronously.
        send_bits(mkframe(8'h72, 1'b0), 5, HF);
        reset = 1'b1;
        #1;
        check("midrst_keys", 32'(keys_now()), 32'd0);
        check("midrst_scan_code", 32'(scan_code), 32'd0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (HF) @(negedge clk);
        e0 = err_cnt;
        exp_q.push_back('{8'h72, 1'b0, 1'b0});
        send_bits(mkframe(8'h72, 1'b0), 11, HF);
        repeat (FL + 10) @(negedge clk);
        check("after_rst_keys", 32'(keys_now()), 32'b01000);
        check("after_rst_err", 32'(err_cnt - e0), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
